sram_axi_master_bridge: RTL
===========================

Name:
sram_axi_master_bridge

Overview:
- Converts a single-outstanding, SRAM-like requester port (CPU/debug side) into a 32-bit AXI master issuing single-beat reads and writes.
- It is the initiator-side counterpart of the AXI-slave-to-SRAM bridge that fronts peripherals such as the UART wrapper.
- Drives the interconnect that those peripheral slaves hang off.

Parameters:
AXI_ID, 4'd0, constant value driven on arid/awid/wid

Ports:
aclk  in  1  clock
rst  in  1  synchronous active-high reset
cpu_req  in  1  request valid
cpu_wr  in  1  1=write, 0=read
cpu_size  in  2  0=byte, 1=half, 2=word
cpu_wstrb  in  4  write byte enables, pre-aligned by requester
cpu_addr  in  32  byte address
cpu_wdata  in  32  write data, pre-aligned
cpu_addr_ok  out  1  request accepted this cycle
cpu_data_ok  out  1  one-cycle completion pulse
cpu_rdata  out  32  read data, valid while cpu_data_ok=1
cpu_err  out  1  completion response was not OKAY; valid while cpu_data_ok=1
arid/awid/wid  out  4  =AXI_ID
araddr/awaddr  out  32  latched cpu_addr
arsize/awsize  out  3  {1'b0, latched cpu_size}
arlen/awlen  out  8  0
arburst/awburst  out  2  2'b01
arlock/awlock  out  2  0
arcache/awcache  out  4  0
arprot/awprot  out  3  0
arvalid  out  1  read address valid
arready  in  1  read address ready
rid  in  4  ignored
rdata  in  32  read data
rresp  in  2  read response
rlast  in  1  ignored (single beat)
rvalid  in  1  read data valid
rready  out  1  read data ready
awvalid  out  1  write address valid
awready  in  1  write address ready
wdata  out  32  latched cpu_wdata
wstrb  out  4  latched cpu_wstrb
wlast  out  1  constant 1
wvalid  out  1  write data valid
wready  in  1  write data ready
bid  in  4  ignored
bresp  in  2  write response
bvalid  in  1  write response valid
bready  out  1  write response ready

Behaviour:
- Reset: state IDLE, all AXI valids 0, rready=0, bready=0, cpu_data_ok=0, cpu_err=0, cpu_rdata=0, latched request regs 0.
- Reset mid-transaction returns to IDLE at the next edge and drops all valids. System reset covers both AXI ends.
- States: IDLE, RD_A, RD_D, WR_AW, WR_B.
- cpu_addr_ok is combinational: cpu_req && state==IDLE.
- Accept (cpu_req && cpu_addr_ok) latches wr/size/addr/wstrb/wdata.
  - Read accept: go to RD_A, arvalid=1 from the next cycle.
  - Write accept: go to WR_AW, awvalid=1 and wvalid=1 from the next cycle.
- RD_A: hold arvalid and araddr stable until arready. On handshake, clear arvalid and go to RD_D.
- RD_D: rready=1. On rvalid, register cpu_rdata<=rdata and cpu_err<=(rresp!=0), then go to IDLE. cpu_data_ok=1 for exactly the following cycle.
- WR_AW: awvalid and wvalid clear independently on their own handshakes, including in the same cycle. When both are done (either done earlier or in this cycle), go to WR_B.
- WR_B: bready=1. On bvalid, cpu_err<=(bresp!=0), go to IDLE, and pulse cpu_data_ok the next cycle. cpu_rdata holds its previous value.
- The cpu_data_ok cycle coincides with IDLE, so a new request may be accepted in that same cycle (back-to-back).
- A non-OKAY response still completes normally; it is flagged only on cpu_err.
- Exactly one transaction is outstanding at a time. No address alignment check. cpu_wstrb and cpu_wdata are ignored for reads.
- Minimum latency, accept to data_ok, with zero-wait slaves: read 3 cycles, write 3 cycles.

Test Plan:
1. Read 0x1fe001e0, arready=1, rvalid the cycle after the AR handshake with rdata=0x12345678 -> data_ok at accept+3, cpu_rdata=0x12345678, cpu_err=0, arsize=3'b010, arlen=0.
2. Write byte 0xa5 to 0x1fe001e0, wstrb=4'b0001, size=0; wready asserted 2 cycles before awready -> wvalid drops first, awvalid held with address stable, bready only after both handshakes, data_ok one cycle after bvalid, awsize=0, wlast=1.
3. Read with arready delayed 5 cycles -> arvalid and araddr stable for 6 cycles, cpu_addr_ok=0 throughout, exactly one AR handshake.
4. Write with bresp=2'b10 -> cpu_data_ok=1 with cpu_err=1, then return to IDLE. A following read with rresp=0 -> cpu_err=0.
5. cpu_req held high for read then write, zero-wait slave -> second accept in the same cycle as the first cpu_data_ok, no idle bubble.
6. rst asserted while in WR_AW with awvalid=1 -> next cycle all valids=0, state IDLE, cpu_data_ok never pulses for the aborted write.

Source files
------------

// File: rtl/sram_axi_master_bridge.sv
// Bridges a single-outstanding SRAM-like requester onto a 32-bit AXI master port.
// Only single-beat INCR transfers are issued, and only one transaction is in flight at a time.
module sram_axi_master_bridge #(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic        aclk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_size,
  input  logic [3:0]  cpu_wstrb,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B} state_e;

  state_e      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic        arvalid_q, arvalid_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        rready_q, rready_d;
  logic        bready_q, bready_d;
  logic        data_ok_q, data_ok_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        aw_done, w_done;

  // Beat IDs, last flags and the write-response ID carry no information here.
  logic unused_inputs;
  assign unused_inputs = ^{rid, rlast, bid};

  // A channel counts as done if it already handshook earlier or does so this cycle.
  assign aw_done = !awvalid_q || awready;
  assign w_done  = !wvalid_q  || wready;

  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    arvalid_d = arvalid_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    rready_d  = rready_q;
    bready_d  = bready_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    data_ok_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          size_d = cpu_size;
          addr_d = cpu_addr;
          if (cpu_wr) begin
            wstrb_d   = cpu_wstrb;
            wdata_d   = cpu_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_AW;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_A;
          end
        end
      end
      RD_A: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_D;
        end
      end
      RD_D: begin
        if (rvalid) begin
          rdata_d   = rdata;
          err_d     = (rresp != 2'b00);
          rready_d  = 1'b0;
          data_ok_d = 1'b1;
          state_d   = IDLE;
        end
      end
      WR_AW: begin
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = WR_B;
        end
      end
      WR_B: begin
        if (bvalid) begin
          err_d     = (bresp != 2'b00);
          bready_d  = 1'b0;
          data_ok_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q   <= IDLE;
      size_q    <= 2'd0;
      addr_q    <= 32'd0;
      wstrb_q   <= 4'd0;
      wdata_q   <= 32'd0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      rready_q  <= 1'b0;
      bready_q  <= 1'b0;
      data_ok_q <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wstrb_q   <= wstrb_d;
      wdata_q   <= wdata_d;
      arvalid_q <= arvalid_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      rready_q  <= rready_d;
      bready_q  <= bready_d;
      data_ok_q <= data_ok_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign cpu_addr_ok = cpu_req && (state_q == IDLE);
  assign cpu_data_ok = data_ok_q;
  assign cpu_rdata   = rdata_q;
  assign cpu_err     = err_q;

  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, size_q};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, size_q};
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = awvalid_q;

  assign wid    = AXI_ID;
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_q;
  assign wlast  = 1'b1;
  assign wvalid = wvalid_q;
  assign bready = bready_q;

endmodule
